// File: rtl/ex_mc_sequencer_if.sv
// Handshake and ALU bundle between ID/EX, the execute sequencer, the ALU and EX/MEM.
// The slave modport is the sequencer. The master modport is its environment: upstream, ALU and downstream.
// No storage here; the interface only groups the signals.
interface ex_mc_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_float;
   logic [4:0]  in_alusel;
   logic [2:0]  in_rm;
   logic [31:0] in_data1;
   logic [31:0] in_data2;
   logic [31:0] in_data3;
   logic [4:0]  in_rd;
   logic        flush;
   logic        alu_float_inst;
   logic [4:0]  alu_sel;
   logic [2:0]  alu_rm;
   logic [31:0] alu_data1;
   logic [31:0] alu_data2;
   logic [31:0] alu_data3;
   logic [31:0] alu_out;
   logic [4:0]  alu_flags;
   logic        alu_done;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_flags;
   logic [4:0]  out_rd;
   logic        busy;
   logic        err_timeout;

   modport slave (
      input  in_valid, in_float, in_alusel, in_rm, in_data1, in_data2, in_data3, in_rd,
      input  flush, alu_out, alu_flags, alu_done, out_ready,
      output in_ready, alu_float_inst, alu_sel, alu_rm, alu_data1, alu_data2, alu_data3,
      output out_valid, out_result, out_flags, out_rd, busy, err_timeout
   );

   modport master (
      output in_valid, in_float, in_alusel, in_rm, in_data1, in_data2, in_data3, in_rd,
      output flush, alu_out, alu_flags, alu_done, out_ready,
      input  in_ready, alu_float_inst, alu_sel, alu_rm, alu_data1, alu_data2, alu_data3,
      input  out_valid, out_result, out_flags, out_rd, busy, err_timeout
   );
endinterface

// File: rtl/ex_mc_sequencer.sv
// Execute-stage sequencer holding ALU inputs stable until alu_done, then presenting the result.
// Latency: accept -> EXEC next cycle -> out_valid one cycle after the first alu_done.
// Backpressure: result held in HOLD until out_ready; in_ready = out_ready there, 0 in EXEC/DRAIN or on flush.
// Optional watchdog enabled by the EX_SEQ_WATCHDOG_EN macro.
module ex_mc_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic               clk,
   input logic               rst,
   ex_mc_sequencer_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   typedef struct packed {
      logic        fl;
      logic [4:0]  sel;
      logic [2:0]  rm;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] d3;
      logic [4:0]  rd;
   } op_t;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   logic [1:0]  state_q, state_d;
   op_t         op_q, op_d;
   logic [31:0] res_q, res_d;
   logic [4:0]  flags_q, flags_d;
   logic [4:0]  ord_q, ord_d;
   logic        in_ready_c;
   logic        accept;
   logic        busy_c;
   logic        wd_hit;

   assign busy_c = (state_q == S_EXEC) || (state_q == S_DRAIN);
   assign accept = bus.in_valid && in_ready_c;

   // Ready: idle always accepts, HOLD accepts only when its result leaves; flush blocks both.
   always_comb begin
      in_ready_c = 1'b0;
      if (!bus.flush) begin
         case (state_q)
            S_IDLE:  in_ready_c = 1'b1;
            S_HOLD:  in_ready_c = bus.out_ready;
            default: in_ready_c = 1'b0;
         endcase
      end
   end

   // Next state, operation latch and result capture.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      res_d   = res_q;
      flags_d = flags_q;
      ord_d   = ord_q;
      if (accept) begin
         op_d.fl  = bus.in_float;
         op_d.sel = bus.in_alusel;
         op_d.rm  = bus.in_rm;
         op_d.d1  = bus.in_data1;
         op_d.d2  = bus.in_data2;
         op_d.d3  = bus.in_data3;
         op_d.rd  = bus.in_rd;
      end
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_EXEC;
         end
         S_EXEC: begin
            if (bus.alu_done) begin
               if (bus.flush) begin
                  state_d = S_IDLE;
               end else begin
                  res_d   = bus.alu_out;
                  flags_d = op_q.fl ? bus.alu_flags : 5'd0;
                  ord_d   = op_q.rd;
                  state_d = S_HOLD;
               end
            end else if (wd_hit) begin
               // Stuck sub-unit: hand back a zero result so the pipeline can move on.
               res_d   = 32'd0;
               flags_d = 5'd0;
               ord_d   = op_q.rd;
               state_d = bus.flush ? S_IDLE : S_HOLD;
            end else if (bus.flush) begin
               // Sub-unit cannot be aborted; wait for it to finish and drop the result.
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (bus.alu_done || wd_hit) state_d = S_IDLE;
         end
         default: begin
            if (bus.flush)          state_d = S_IDLE;
            else if (bus.out_ready) state_d = accept ? S_EXEC : S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         res_q   <= '0;
         flags_q <= '0;
         ord_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         ord_q   <= ord_d;
      end
   end

`ifdef EX_SEQ_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic             err_q;

   assign wd_hit = busy_c && !bus.alu_done && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog count: zero on entry to EXEC/DRAIN, +1 per cycle while staying there.
   always_comb begin
      wd_cnt_d = '0;
      if (((state_d == S_EXEC) || (state_d == S_DRAIN)) && (state_d != state_q))
         wd_cnt_d = '0;
      else if (busy_c)
         wd_cnt_d = wd_cnt_q + CNT_W'(1);
   end

   // Watchdog counter and one-cycle timeout pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= wd_hit;
      end
   end

   assign bus.err_timeout = err_q;
`else
   assign wd_hit          = 1'b0;
   assign bus.err_timeout = 1'b0;
`endif

   // ALU drive is a function of registered state only, parked outside EXEC/DRAIN.
   assign bus.alu_float_inst = busy_c ? op_q.fl  : 1'b0;
   assign bus.alu_sel        = busy_c ? op_q.sel : 5'd0;
   assign bus.alu_rm         = busy_c ? op_q.rm  : 3'd0;
   assign bus.alu_data1      = busy_c ? op_q.d1  : 32'd0;
   assign bus.alu_data2      = busy_c ? op_q.d2  : 32'd0;
   assign bus.alu_data3      = busy_c ? op_q.d3  : 32'd0;

   assign bus.in_ready   = in_ready_c;
   assign bus.busy       = busy_c;
   assign bus.out_valid  = (state_q == S_HOLD);
   assign bus.out_result = res_q;
   assign bus.out_flags  = flags_q;
   assign bus.out_rd     = ord_q;

endmodule

// File: tb/tb_ex_mc_sequencer.sv
// Directed bench for ex_mc_sequencer with an ALU stub of programmable latency.
// Expected results are queued at accept and compared when out_valid appears.
// Watchdog checks follow EX_SEQ_WATCHDOG_EN.
module tb_ex_mc_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ex_mc_sequencer_if bus();

   ex_mc_sequencer #(.TIMEOUT_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  flags;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   int   vecs = 0;
   int   errs = 0;

   int       stub_lat   = 0;
   bit       stub_never = 1'b0;
   logic [7:0] stub_cnt;

   // ALU stub: counts busy cycles, raises done once the programmed latency has elapsed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          stub_cnt <= '0;
      else if (bus.busy) stub_cnt <= stub_cnt + 8'd1;
      else               stub_cnt <= '0;
   end

   always_comb begin
      bus.alu_done  = bus.busy && !stub_never && (int'(stub_cnt) >= stub_lat);
      bus.alu_flags = bus.alu_float_inst ? 5'b00001 : 5'b10101;
      bus.alu_out   = bus.alu_data1 ^ bus.alu_data2;
      if (bus.alu_float_inst) begin
         bus.alu_out = bus.alu_data1 + bus.alu_data2;
      end else begin
         case (bus.alu_sel)
            5'b00000: bus.alu_out = bus.alu_data1 + bus.alu_data2;
            5'b10000: bus.alu_out = bus.alu_data1 * bus.alu_data2;
            5'b10100: bus.alu_out = (bus.alu_data2 == 32'd0) ? 32'hFFFF_FFFF :
                                    32'($signed(bus.alu_data1) / $signed(bus.alu_data2));
            default:  bus.alu_out = bus.alu_data1 ^ bus.alu_data2;
         endcase
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic fl, input logic [4:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
      bit ok;
      ok = 1'b0;
      bus.in_float  = fl;
      bus.in_alusel = sel;
      bus.in_rm     = 3'd1;
      bus.in_data1  = a;
      bus.in_data2  = b;
      bus.in_data3  = a ^ b;
      bus.in_rd     = rd;
      bus.in_valid  = 1'b1;
      #1;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("accept", {31'd0, ok}, 32'd1);
      if (ok) tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, output int lat);
      exp_t e;
      lat = 0;
      while (!bus.out_valid && lat < 60) begin
         tick();
         lat++;
      end
      chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_sb"}, {31'd0, sb.size() > 0}, 32'd1);
      if (bus.out_valid && sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_res"}, bus.out_result, e.res);
         chk({tag, "_flags"}, {27'd0, bus.out_flags}, {27'd0, e.flags});
         chk({tag, "_rd"}, {27'd0, bus.out_rd}, {27'd0, e.rd});
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
   endtask

   initial begin
      int lat;
      int n;
      bus.in_valid  = 1'b0;
      bus.in_float  = 1'b0;
      bus.in_alusel = '0;
      bus.in_rm     = '0;
      bus.in_data1  = '0;
      bus.in_data2  = '0;
      bus.in_data3  = '0;
      bus.in_rd     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      #3;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_alu_sel", {27'd0, bus.alu_sel}, 32'd0);
      chk("rst_alu_data1", bus.alu_data1, 32'd0);
      chk("rst_err", {31'd0, bus.err_timeout}, 32'd0);
      chk("rst_result", bus.out_result, 32'd0);
      do_reset();

      // ADD 5 + 7, single-cycle
      stub_lat = 0;
      send(1'b0, 5'b00000, 32'd5, 32'd7, 5'd3);
      sb.push_back('{res: 32'd12, flags: 5'd0, rd: 5'd3});
      chk("add_busy_exec", {31'd0, bus.busy}, 32'd1);
      chk("add_alu_data1", bus.alu_data1, 32'd5);
      wait_out("add", lat);
      chk("add_lat", lat, 32'd1);
      chk("add_busy_hold", {31'd0, bus.busy}, 32'd0);
      tick();

      // DIV -100 / 7, operands held through EXEC
      stub_lat = 3;
      send(1'b0, 5'b10100, -32'sd100, 32'd7, 5'd4);
      sb.push_back('{res: 32'hFFFF_FFF2, flags: 5'd0, rd: 5'd4});
      n = 0;
      while (!bus.out_valid && n < 40) begin
         chk("div_alu_data1", bus.alu_data1, -32'sd100);
         chk("div_alu_data2", bus.alu_data2, 32'd7);
         chk("div_alu_sel", {27'd0, bus.alu_sel}, 32'b10100);
         tick();
         n++;
      end
      chk("div_lat", n, 32'd4);
      wait_out("div", lat);
      tick();

      // Float op: flags pass through
      stub_lat = 1;
      send(1'b1, 5'b00000, 32'h3F80_0000, 32'h4000_0000, 5'd7);
      sb.push_back('{res: 32'h7F80_0000, flags: 5'b00001, rd: 5'd7});
      chk("fp_alu_float", {31'd0, bus.alu_float_inst}, 32'd1);
      wait_out("fp", lat);
      tick();

      // Back-pressure: ADD 1 + 1 held, next op accepted when out_ready rises
      stub_lat = 0;
      bus.out_ready = 1'b0;
      send(1'b0, 5'b00000, 32'd1, 32'd1, 5'd5);
      sb.push_back('{res: 32'd2, flags: 5'd0, rd: 5'd5});
      wait_out("bp", lat);
      bus.in_alusel = 5'b00000;
      bus.in_float  = 1'b0;
      bus.in_data1  = 32'd10;
      bus.in_data2  = 32'd20;
      bus.in_rd     = 5'd6;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp_hold_result", bus.out_result, 32'd2);
         chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_in_ready_rise", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      sb.push_back('{res: 32'd30, flags: 5'd0, rd: 5'd6});
      chk("bp_next_exec", {31'd0, bus.busy}, 32'd1);
      chk("bp_next_valid", {31'd0, bus.out_valid}, 32'd0);
      wait_out("bp2", lat);
      tick();

      // Flush while a result is held
      bus.out_ready = 1'b0;
      send(1'b0, 5'b00000, 32'd2, 32'd2, 5'd9);
      tick();
      chk("hflush_valid_pre", {31'd0, bus.out_valid}, 32'd1);
      bus.flush = 1'b1;
      #1;
      chk("hflush_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      chk("hflush_valid_post", {31'd0, bus.out_valid}, 32'd0);
      chk("hflush_busy", {31'd0, bus.busy}, 32'd0);

      // Flush two cycles into DIV: drain, then a fresh ADD
      stub_lat = 5;
      send(1'b0, 5'b10100, -32'sd100, 32'd7, 5'd8);
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      n = 0;
      while (n < 40) begin
         chk("drain_busy", {31'd0, bus.busy}, 32'd1);
         chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
         chk("drain_in_ready", {31'd0, bus.in_ready}, 32'd0);
         if (bus.alu_done) break;
         tick();
         n++;
      end
      chk("drain_len", n, 32'd3);
      tick();
      chk("drain_idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("drain_idle_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("drain_idle_valid", {31'd0, bus.out_valid}, 32'd0);
      stub_lat = 0;
      send(1'b0, 5'b00000, 32'd3, 32'd4, 5'd1);
      sb.push_back('{res: 32'd7, flags: 5'd0, rd: 5'd1});
      wait_out("post_drain", lat);
      tick();

      // Reset mid-MUL, then MUL 6 x 7
      stub_lat = 3;
      send(1'b0, 5'b10000, 32'd6, 32'd7, 5'd2);
      tick();
      chk("mul_alu_sel", {27'd0, bus.alu_sel}, 32'b10000);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_busy", {31'd0, bus.busy}, 32'd0);
      chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("arst_alu_sel", {27'd0, bus.alu_sel}, 32'd0);
      chk("arst_alu_data1", bus.alu_data1, 32'd0);
      chk("arst_alu_data2", bus.alu_data2, 32'd0);
      chk("arst_result", bus.out_result, 32'd0);
      chk("arst_err", {31'd0, bus.err_timeout}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      send(1'b0, 5'b10000, 32'd6, 32'd7, 5'd2);
      sb.push_back('{res: 32'd42, flags: 5'd0, rd: 5'd2});
      wait_out("mul", lat);
      chk("mul_lat", lat, 32'd4);
      tick();

      // ALU that never completes
      stub_never = 1'b1;
      send(1'b0, 5'b00000, 32'd9, 32'd9, 5'd3);
`ifdef EX_SEQ_WATCHDOG_EN
      for (int i = 0; i < 8; i++) begin
         chk("wd_err_quiet", {31'd0, bus.err_timeout}, 32'd0);
         chk("wd_busy", {31'd0, bus.busy}, 32'd1);
         tick();
      end
      chk("wd_err_pulse", {31'd0, bus.err_timeout}, 32'd1);
      chk("wd_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("wd_result", bus.out_result, 32'd0);
      chk("wd_flags", {27'd0, bus.out_flags}, 32'd0);
      tick();
      chk("wd_err_clear", {31'd0, bus.err_timeout}, 32'd0);
      stub_never = 1'b0;
`else
      for (int i = 0; i < 20; i++) begin
         chk("hang_busy", {31'd0, bus.busy}, 32'd1);
         chk("hang_err", {31'd0, bus.err_timeout}, 32'd0);
         tick();
      end
      stub_never = 1'b0;
      do_reset();
`endif

      chk("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/ex_mc_sequencer.md
# ex_mc_sequencer

Execute-stage issue sequencer that drives the multi-cycle integer/float ALU through its level-held request / `done` protocol. It registers one decoded operation from ID/EX, holds the ALU inputs stable until `alu_done`, captures the result, and presents it to EX/MEM with a valid/ready handshake. It also absorbs flushes that arrive mid-operation, because the mul/div/FPU sub-units cannot be aborted.

## Interface
- `TIMEOUT_CYCLES`, 64: watchdog limit, in cycles in EXEC or DRAIN; ≥2.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream operation valid.
- `in_ready` out 1: sequencer accepts this cycle.
- `in_float` in 1: floating-point instruction.
- `in_alusel` in 5: ALU select, {func7[0], func7[5], func3}.
- `in_rm` in 3: FP rounding mode.
- `in_data1`, `in_data2`, `in_data3` in 32 each: operands.
- `in_rd` in 5: destination tag.
- `flush` in 1: discard the in-flight operation.
- `alu_float_inst` out 1, `alu_sel` out 5, `alu_rm` out 3: ALU controls.
- `alu_data1`, `alu_data2`, `alu_data3` out 32 each: ALU operands.
- `alu_out` in 32, `alu_flags` in 5, `alu_done` in 1: ALU response; `alu_done` may be combinational.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_result` out 32, `out_flags` out 5, `out_rd` out 5: captured result.
- `busy` out 1: high in EXEC or DRAIN (pipeline stall).
- `err_timeout` out 1: one-cycle watchdog pulse.

## Operation
- States: IDLE, EXEC, DRAIN, HOLD. Reset state is IDLE. All registered outputs reset to 0.
- IDLE:
  - `in_ready`=1.
  - ALU drive is parked at `alu_float_inst`=0, `alu_sel`=0 (add), operands 0, so no sub-unit starts.
  - On `in_valid`: latch the operation and go to EXEC.
- EXEC:
  - ALU ports are driven from the latched registers and held constant.
  - On `alu_done`=1: capture `alu_out`, `alu_rd` and flags, then go to HOLD.
  - `out_flags` = `alu_flags` for float operations, 0 for integer operations.
- DRAIN:
  - Same ALU drive as EXEC.
  - On `alu_done`: discard the result and go to IDLE.
- HOLD:
  - `out_valid`=1.
  - On `out_ready`: clear `out_valid`.
  - `in_ready`=`out_ready`. A new `in_valid` in the same cycle is latched and the next state is EXEC; otherwise the next state is IDLE.
- `flush`:
  - In IDLE or HOLD: drop any valid or held result; next state IDLE; same-cycle `in_valid` is ignored.
  - In EXEC with `alu_done`=1: go to IDLE, result discarded.
  - In EXEC with `alu_done`=0: go to DRAIN.
  - In DRAIN: no effect.
- `in_ready`=0 whenever `flush`=1.
- The latched operation is never modified outside an accept.

## Timing
- Single-cycle operation (ALU `done` same cycle):
  - Accept at cycle N, EXEC at N+1, `out_valid` at N+2.
  - Throughput is 1 per 2 cycles.
- Multi-cycle operation: `out_valid` one cycle after the first EXEC cycle with `alu_done`=1.
- `busy` is combinational from state.
- `alu_*` outputs change only on state-register updates.
- Reset is asserted asynchronously and released synchronously to `clk` by the system.
- Reset mid-operation:
  - The sequencer returns to IDLE and parks the ALU immediately.
  - The sub-units are reset by the same `rst`.
- The sub-unit request is level-held by the ALU, so the sequencer never pulses controls.

## Configuration
- `EX_SEQ_WATCHDOG_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to EXEC or DRAIN and increments every cycle there.
  - On reaching `TIMEOUT_CYCLES` without `alu_done`:
    - `err_timeout` pulses for 1 cycle.
    - From EXEC, go to HOLD with `out_result`=0 and `out_flags`=0.
    - From DRAIN, go to IDLE.
- `EX_SEQ_WATCHDOG_EN` undefined: no counter, `err_timeout` tied to 0, and the sequencer waits indefinitely.

## Test plan
- ADD, 5 + 7, `in_float`=0, `out_ready`=1:
  - `out_result`=12 and `out_flags`=0 two cycles after accept.
  - `busy` high for exactly 1 cycle.
- DIV, -100 / 7, `alu_sel`=5'b10100:
  - `out_result`=0xFFFF_FFF2 one cycle after the first `alu_done`.
  - `alu_data*` are stable throughout EXEC.
- Back-pressure, ADD 1 + 1 with `out_ready`=0 for 4 cycles:
  - `out_valid` and `out_result`=2 are held.
  - `in_ready`=0.
  - The next operation is accepted in the cycle `out_ready` rises.
- Flush two cycles into DIV:
  - State is DRAIN, with no `out_valid` and `in_ready`=0 until `alu_done`.
  - IDLE the cycle after `alu_done`.
  - A following ADD 3 + 4 gives 7.
- Reset asserted mid-MUL:
  - All outputs 0 and state IDLE asynchronously.
  - After release, MUL 6 × 7 gives 42.
- With `EX_SEQ_WATCHDOG_EN`, `TIMEOUT_CYCLES`=8, ALU stub that never asserts `done`:
  - `err_timeout` pulses 8 cycles after entering EXEC.
  - Then `out_valid`=1 with `out_result`=0.
